shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential unsigned integer multiplier, the inverse operation of the restoring
//  unsigned divider: P = A * B by iterative shift-and-add, one multiplier bit per clock.
//  Sits beside the divider in the arithmetic unit and shares its handshake style
//  (operands in, done out).
//  Also serves as the round-trip checker for divider benches: P = Q*B, then add Rem.
// PARAMETERS
//  WIDTH  8  operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
// PORTS
//  clk    in   1        rising-edge clock
//  reset  in   1        asynchronous, active-low reset (0 = reset asserted)
//  start  in   1        request; sampled on rising clk only in IDLE
//  A      in   WIDTH    multiplicand, unsigned; captured on the accepted start edge
//  B      in   WIDTH    multiplier, unsigned; captured on the accepted start edge
//  busy   out  1        high while in RUN
//  done   out  1        one-cycle pulse when P holds a new result
//  P      out  2*WIDTH  product, unsigned; held stable until the next accepted start
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, P=0.
//   All internal registers (mcand, acc, mplr, carry, count) are cleared to 0.
//   Reset releases synchronously to clk.
//  Internal registers:
//   mcand[W], acc[W], mplr[W], carry[1], count[log2(W)+1].
//  States:
//   IDLE: busy=0, done=0.
//    start=1 at edge k -> load mcand=A, mplr=B, acc=0, carry=0, count=W -> RUN.
//   RUN: busy=1. On each edge:
//    {carry,acc} = acc + (mplr[0] ? mcand : 0)   (W+1-bit sum, no overflow lost)
//    then shift {carry,acc,mplr} right 1; carry <= 0; count <= count-1.
//    When count reaches 1 on this edge -> DONE, with P <= {acc,mplr} after the final
//    shift, so P = A*B exactly (max (2^W-1)^2 fits in 2W bits).
//   DONE: busy=0, done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
//  Latency: done=1 in the cycle after edge k+W, where edge k is the start edge.
//   Throughput: one result per W+2 cycles.
//  Operands: A/B changes after the start edge have no effect on the running result.
//  start while busy=1, or in the DONE cycle: ignored; no queueing, no restart.
//  start held high continuously: a new operation starts at each IDLE visit.
//  Zero operand: no early exit; full W iterations; P=0.
//  P is updated only on the RUN->DONE edge. P is not modified during RUN.
//   It keeps the previous result until the next done.
//  Reset asserted mid-RUN: operation abandoned immediately; outputs at reset values.
//   A new start is required after reset releases.
// TESTING
//  1. W=8, A=102, B=4, start 1 cycle -> busy 8 cycles; done 1 cycle after edge k+8;
//     P=408 (16'h0198).
//  2. A=255, B=255 -> P=65025 (16'hFE01); checks the carry path on each add.
//     A=0, B=173 -> P=0 after full latency.
//  3. start pulsed at cycles 3 and 6 of RUN with different A/B -> ignored;
//     result matches the first operands; exactly one done pulse.
//  4. reset=0 during RUN cycle 4 -> busy=0, done=0, P=0 immediately (async);
//     then A=13, B=11 -> P=143.
//  5. start held high, operand pairs (7,9), (200,3) -> back-to-back results 63 and 600;
//     done pulses W+2 cycles apart; P stable between done pulses.
//  6. Round trip with divider: A=102, B=4 gives Q=25, Rem=2.
//     Feed Q=25, B=4 here -> P=100; P + Rem = 102 = A.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned multiplier, P = A * B, one multiplier bit per clock
//   using iterative shift-and-add. Operands are captured when start is
//   accepted in IDLE. The result appears W+1 cycles after the start edge and
//   is held until the next result.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  operation request, honoured only in IDLE
//   A      multiplicand, WIDTH bits unsigned
//   B      multiplier, WIDTH bits unsigned
//   busy   high while iterating
//   done   one-cycle pulse when P holds a new result
//   P      product, 2*WIDTH bits unsigned
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;

  // W+1-bit partial sum so the add carry is never lost before the shift.
  always_comb begin
    sum = {carry, acc} + {1'b0, (mplr[0] ? mcand : '0)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      carry <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= A;
            mplr  <= B;
            acc   <= '0;
            carry <= 1'b0;
            count <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // {carry,acc,mplr} shifted right by one: the sum's low bit enters
          // the top of mplr, which ends up holding the low product half.
          acc   <= sum[WIDTH:1];
          mplr  <= {sum[0], mplr[WIDTH-1:1]};
          carry <= 1'b0;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            P     <= {sum, mplr[WIDTH-1:1]};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier with WIDTH=8: a vector table of
//   operand pairs and hand-computed products, plus sequences for ignored
//   starts, mid-run reset, held start and the divider round trip.
module tb_shift_add_multiplier;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int unsigned n_checks;
  int unsigned n_fail;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .P     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one start and follow the operation to its done pulse.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [2*W-1:0] exp, input string name);
    logic [2*W-1:0] prev_p;
    int unsigned    cycles;
    int unsigned    busy_cnt;
    bit             got;
    bit             p_stable;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~va;      // operands must already be captured
    b = ~vb;
    prev_p = p;
    cycles = 0;
    busy_cnt = 0;
    got = 1'b0;
    p_stable = 1'b1;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (p !== prev_p) p_stable = 1'b0;
      end
    end
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, cycles, W + 1);
    chk({name, " busy_cycles"}, busy_cnt, W);
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    chk({name, " p_held_in_run"}, 32'(p_stable), 32'd1);
    chk({name, " product"}, 32'(p), 32'(exp));
    @(negedge clk);
    chk({name, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned done_cnt;
    int unsigned d1;
    int unsigned d2;
    logic [2*W-1:0] p1;
    logic [2*W-1:0] p2;
    bit stable;

    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{8'd102, 8'd4,   16'd408};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd173, 16'd0};
    vecs[3] = '{8'd1,   8'd1,   16'd1};
    vecs[4] = '{8'd255, 8'd0,   16'd0};
    vecs[5] = '{8'd128, 8'd2,   16'd256};
    vecs[6] = '{8'd13,  8'd11,  16'd143};
    vecs[7] = '{8'd170, 8'd85,  16'd14450};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset p", 32'(p), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle no start busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].prod, $sformatf("vec%0d", i));
    end

    // Starts during RUN are ignored; exactly one done with first operands.
    @(negedge clk);
    a = 8'd102; b = 8'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("ignored_start product", 32'(p), 32'd408);
      end
      start = (c == 3 || c == 6);
      a = 8'd50; b = 8'd60;
    end
    start = 1'b0;
    chk("ignored_start done_count", done_cnt, 32'd1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'd200; b = 8'd200; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset busy", 32'(busy), 32'd0);
    chk("async_reset done", 32'(done), 32'd0);
    chk("async_reset p", 32'(p), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("no_resume_after_reset", done_cnt, 32'd0);
    run_op(8'd13, 8'd11, 16'd143, "post_reset");

    // Start held high: back-to-back operations W+2 cycles apart.
    @(negedge clk);
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd200; b = 8'd3;
    cyc = 0; d1 = 0; d2 = 0; p1 = '0; p2 = '0; stable = 1'b1;
    while (d2 == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (d1 == 0) begin d1 = cyc; p1 = p; end
        else begin d2 = cyc; p2 = p; start = 1'b0; end
      end else if (d1 != 0 && p !== p1) stable = 1'b0;
    end
    start = 1'b0;
    chk("held first_product", 32'(p1), 32'd63);
    chk("held second_product", 32'(p2), 32'd600);
    chk("held spacing", d2 - d1, W + 2);
    chk("held p_stable_between", 32'(stable), 32'd1);
    repeat (3) @(negedge clk);
    chk("held stops busy", 32'(busy), 32'd0);

    // Divider round trip: 102 / 4 = 25 rem 2.
    run_op(8'd25, 8'd4, 16'd100, "roundtrip");
    chk("roundtrip p_plus_rem", 32'(p) + 32'd2, 32'd102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
